wb_dma_master: RTL

WB_DMA_MASTER -- requirements
Module: wb_dma_master

---
 rtl/wb_dma_pkg.sv | 19 +
 rtl/wb_ack_timer.sv | 33 +++
 rtl/wb_dma_master.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/wb_dma_pkg.sv
// Shared definitions for the Wishbone word-copy DMA master: FSM state encoding,
// byte-lane select constant and address helpers.
package wb_dma_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      FIN  = 2'd3
   } state_t;

   localparam logic [3:0]  SEL_ALL    = 4'hF;
   localparam logic [31:0] WORD_BYTES = 32'd4;

   function automatic logic [31:0] word_align(input logic [31:0] adr);
      return {adr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/wb_ack_timer.sv
// Per-access watchdog: counts cycles an access waits for ack/err and flags
// expiry on the TIMEOUT-th waiting cycle.
module wb_ack_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic wb_clk_i,
   input  logic wb_rst_n_i,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] cnt;

   // Expiry is seen during the last permitted waiting cycle so the FSM leaves
   // on the edge that ends it, giving exactly TIMEOUT strobe cycles.
   assign expired = enable && (cnt == CNT_W'(TIMEOUT - 1));

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable && !expired) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/wb_dma_master.sv
// Wishbone DMA initiator copying len 32-bit words from src to dst, one
// read-then-write pair per word, with err/timeout abort and done pulse.
module wb_dma_master
   import wb_dma_pkg::*;
#(
   parameter int LEN_W   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_n_i,
   input  logic             start_i,
   input  logic [31:0]      src_adr_i,
   input  logic [31:0]      dst_adr_i,
   input  logic [LEN_W-1:0] len_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic [LEN_W-1:0] remain_o,
   output logic             wb_cyc_o,
   output logic             wb_stb_o,
   output logic             wb_we_o,
   output logic [3:0]       wb_sel_o,
   output logic [31:0]      wb_adr_o,
   output logic [31:0]      wb_dat_o,
   input  logic [31:0]      wb_dat_i,
   input  logic             wb_ack_i,
   input  logic             wb_err_i
);

   state_t           state, next_state;
   logic [31:0]      src_q, dst_q, buf_q;
   logic [LEN_W-1:0] remain_q;
   logic             err_q;

   logic [31:0]      src_d, dst_d, buf_d, adr_d;
   logic [LEN_W-1:0] remain_d;
   logic             err_d, cyc_d, we_d;
   logic [3:0]       sel_d;

   logic             in_xfer, timer_clear, expired;

   assign in_xfer     = (state == RD) || (state == WR);
   assign timer_clear = !in_xfer || wb_ack_i || wb_err_i;

   wb_ack_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .wb_clk_i   (wb_clk_i),
      .wb_rst_n_i (wb_rst_n_i),
      .clear      (timer_clear),
      .enable     (in_xfer),
      .expired    (expired)
   );

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) state <= IDLE;
      else             state <= next_state;
   end

   // Error beats ack, ack beats timeout.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (start_i) next_state = (len_i != '0) ? RD : FIN;
         RD: begin
            if (wb_err_i)      next_state = FIN;
            else if (wb_ack_i) next_state = WR;
            else if (expired)  next_state = FIN;
         end
         WR: begin
            if (wb_err_i)      next_state = FIN;
            else if (wb_ack_i) next_state = (remain_q > LEN_W'(1)) ? RD : FIN;
            else if (expired)  next_state = FIN;
         end
         FIN:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // NOTE: every signal assigned here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      src_d    = src_q;
      dst_d    = dst_q;
      buf_d    = buf_q;
      remain_d = remain_q;
      err_d    = err_q;
      case (state)
         IDLE: if (start_i) begin
            src_d    = word_align(src_adr_i);
            dst_d    = word_align(dst_adr_i);
            remain_d = len_i;
            err_d    = 1'b0;
         end
         RD: begin
            if (wb_err_i || (!wb_ack_i && expired)) err_d = 1'b1;
            else if (wb_ack_i)                      buf_d = wb_dat_i;
         end
         WR: begin
            if (wb_err_i || (!wb_ack_i && expired)) err_d = 1'b1;
            else if (wb_ack_i) begin
               src_d    = src_q + WORD_BYTES;
               dst_d    = dst_q + WORD_BYTES;
               remain_d = remain_q - LEN_W'(1);
            end
         end
         default: ;
      endcase
      // Bus outputs are decoded from the upcoming state and then registered,
      // so they line up with the state without a path from wb_ack_i.
      cyc_d = (next_state == RD) || (next_state == WR);
      we_d  = (next_state == WR);
      sel_d = cyc_d ? SEL_ALL : 4'h0;
      adr_d = we_d ? dst_d : src_d;
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         src_q    <= '0;
         dst_q    <= '0;
         buf_q    <= '0;
         remain_q <= '0;
         err_q    <= 1'b0;
         done_o   <= 1'b0;
         wb_cyc_o <= 1'b0;
         wb_stb_o <= 1'b0;
         wb_we_o  <= 1'b0;
         wb_sel_o <= 4'h0;
         wb_adr_o <= '0;
         wb_dat_o <= '0;
      end else begin
         src_q    <= src_d;
         dst_q    <= dst_d;
         buf_q    <= buf_d;
         remain_q <= remain_d;
         err_q    <= err_d;
         done_o   <= (state == FIN);
         wb_cyc_o <= cyc_d;
         wb_stb_o <= cyc_d;
         wb_we_o  <= we_d;
         wb_sel_o <= sel_d;
         wb_adr_o <= adr_d;
         wb_dat_o <= buf_d;
      end
   end

   assign busy_o   = (state != IDLE);
   assign err_o    = err_q;
   assign remain_o = remain_q;

endmodule
